// File: rtl/secuenciador_lectura_rtc.sv
// Periodic read sequencer for the RTC register bank.
// On every poll tick it walks the ten local registers (time, date, weekday, timer),
// issues one RTC bus read per register, and once the read is acknowledged it drives
// the local index together with an active-low capture strobe so the hold decoder
// latches exactly one register. Between registers it yields to the write path.
module secuenciador_lectura_rtc #(
    parameter int POLL_PERIOD = 1_000_000,
    parameter int HOLD_CYC    = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_busy,
    input  logic       bus_ack,
    output logic       bus_req,
    output logic [7:0] rtc_addr,
    output logic [3:0] addr_mem_local,
    output logic       reg_rd,
    output logic       sweep_done,
    output logic       timeout_err
);

    // Counter widths sized to hold 0..N-1, never narrower than one bit.
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int HW = (HOLD_CYC > 1)    ? $clog2(HOLD_CYC)    : 1;

    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd9;
    localparam logic [3:0]    NO_REG    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_STROBE,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t          state_q,          state_d;
    logic [3:0]      idx_q,            idx_d;
    logic [PW-1:0]   poll_cnt_q,       poll_cnt_d;
    logic [WW-1:0]   wait_cnt_q,       wait_cnt_d;
    logic [HW-1:0]   hold_cnt_q,       hold_cnt_d;
    logic            pending_q,        pending_d;
    logic            bus_req_q,        bus_req_d;
    logic [7:0]      rtc_addr_q,       rtc_addr_d;
    logic [3:0]      addr_mem_local_q, addr_mem_local_d;
    logic            reg_rd_q,         reg_rd_d;
    logic            sweep_done_q,     sweep_done_d;
    logic            timeout_err_q,    timeout_err_d;

    logic            tick;
    logic            start_sweep;

    // RTC chip address for each local register index.
    function automatic logic [7:0] addr_for(input logic [3:0] i);
        logic [7:0] a;
        case (i)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h27;
            4'd7:    a = 8'h41;
            4'd8:    a = 8'h42;
            4'd9:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Poll counter: free-runs while enabled, cleared while disabled; tick on wrap.
    always_comb begin
        tick = enable && (poll_cnt_q == POLL_LAST);
        if (!enable) begin
            poll_cnt_d = '0;
        end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d = '0;
        end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
    end

    // Sequencer next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        wait_cnt_d       = wait_cnt_q;
        hold_cnt_d       = hold_cnt_q;
        pending_d        = pending_q;
        bus_req_d        = bus_req_q;
        rtc_addr_d       = rtc_addr_q;
        addr_mem_local_d = addr_mem_local_q;
        reg_rd_d         = reg_rd_q;
        sweep_done_d     = 1'b0;
        timeout_err_d    = 1'b0;
        start_sweep      = (tick || pending_q) && enable && !wr_busy;

        case (state_q)
            ST_IDLE: begin
                if (start_sweep) begin
                    state_d    = ST_REQ;
                    idx_d      = 4'd0;
                    bus_req_d  = 1'b1;
                    rtc_addr_d = addr_for(4'd0);
                    wait_cnt_d = '0;
                    pending_d  = 1'b0;
                end else if (tick && wr_busy) begin
                    pending_d = 1'b1;
                end
            end

            ST_REQ: begin
                if (bus_ack) begin
                    state_d          = ST_STROBE;
                    bus_req_d        = 1'b0;
                    reg_rd_d         = 1'b0;
                    addr_mem_local_d = idx_q;
                    hold_cnt_d       = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_IDLE;
                    bus_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    idx_d         = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_STROBE: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d          = ST_NEXT;
                    reg_rd_d         = 1'b1;
                    addr_mem_local_d = NO_REG;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d      = ST_DONE;
                    sweep_done_d = 1'b1;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end else if (!wr_busy) begin
                    state_d    = ST_REQ;
                    idx_d      = idx_q + 4'd1;
                    bus_req_d  = 1'b1;
                    rtc_addr_d = addr_for(idx_q + 4'd1);
                    wait_cnt_d = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end

            default: begin
                state_d          = ST_IDLE;
                idx_d            = 4'd0;
                bus_req_d        = 1'b0;
                reg_rd_d         = 1'b1;
                addr_mem_local_d = NO_REG;
            end
        endcase
    end

    // All state and outputs registered; synchronous reset aborts any sweep silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= 4'd0;
            poll_cnt_q       <= '0;
            wait_cnt_q       <= '0;
            hold_cnt_q       <= '0;
            pending_q        <= 1'b0;
            bus_req_q        <= 1'b0;
            rtc_addr_q       <= 8'h00;
            addr_mem_local_q <= NO_REG;
            reg_rd_q         <= 1'b1;
            sweep_done_q     <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            poll_cnt_q       <= poll_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            pending_q        <= pending_d;
            bus_req_q        <= bus_req_d;
            rtc_addr_q       <= rtc_addr_d;
            addr_mem_local_q <= addr_mem_local_d;
            reg_rd_q         <= reg_rd_d;
            sweep_done_q     <= sweep_done_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign bus_req        = bus_req_q;
    assign rtc_addr       = rtc_addr_q;
    assign addr_mem_local = addr_mem_local_q;
    assign reg_rd         = reg_rd_q;
    assign sweep_done     = sweep_done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// Directed bench for the RTC read sequencer with a short poll period and ack timeout.
// A small bus responder acks each request in its first cycle unless told to withhold
// one address; a monitor logs request addresses, strobe lengths and pulses at negedge.
module tb_secuenciador_lectura_rtc;

    localparam int POLL = 16;
    localparam int HOLD = 2;
    localparam int ATO  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       wr_busy = 1'b0;
    logic       bus_ack = 1'b0;
    logic       bus_req;
    logic [7:0] rtc_addr;
    logic [3:0] addr_mem_local;
    logic       reg_rd;
    logic       sweep_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [7:0] addr_log [$];
    int         rise_cyc [$];
    int         strobe_cnt [16];
    int         done_cnt;
    int         done_cycle;
    int         timeout_seen;
    int         viol_cnt = 0;
    logic       prev_bus_req = 1'b0;

    logic       auto_ack = 1'b1;
    logic       withhold_en = 1'b0;
    logic [7:0] withhold_addr = 8'h00;

    logic [7:0] exp_addr [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                  8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    secuenciador_lectura_rtc #(
        .POLL_PERIOD (POLL),
        .HOLD_CYC    (HOLD),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .wr_busy        (wr_busy),
        .bus_ack        (bus_ack),
        .bus_req        (bus_req),
        .rtc_addr       (rtc_addr),
        .addr_mem_local (addr_mem_local),
        .reg_rd         (reg_rd),
        .sweep_done     (sweep_done),
        .timeout_err    (timeout_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        addr_log.delete();
        rise_cyc.delete();
        foreach (strobe_cnt[i]) strobe_cnt[i] = 0;
        done_cnt     = 0;
        done_cycle   = 0;
        timeout_seen = 0;
    endtask

    // Advance n cycles: sample at negedge, log activity, then drive the bus responder.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycle++;
            if (bus_req === 1'b1 && prev_bus_req !== 1'b1) begin
                addr_log.push_back(rtc_addr);
                rise_cyc.push_back(cycle);
            end
            prev_bus_req = bus_req;
            if (reg_rd === 1'b0) strobe_cnt[int'(addr_mem_local)]++;
            if (sweep_done === 1'b1) begin
                done_cnt++;
                done_cycle = cycle;
            end
            if (timeout_err === 1'b1) timeout_seen++;
            if ((reg_rd === 1'b1) != (addr_mem_local === 4'hF)) viol_cnt++;
            bus_ack = auto_ack && (bus_req === 1'b1) &&
                      !(withhold_en && rtc_addr == withhold_addr);
        end
    endtask

    task automatic doReset();
        reset       = 1'b1;
        enable      = 1'b0;
        wr_busy     = 1'b0;
        bus_ack     = 1'b0;
        withhold_en = 1'b0;
        auto_ack    = 1'b1;
        applyStimulus(3);
        reset = 1'b0;
        applyStimulus(1);
        clearMonitor();
    endtask

    task automatic waitRises(input int n, input int budget);
        for (int k = 0; k < budget && addr_log.size() < n; k++) applyStimulus(1);
    endtask

    task automatic waitDone(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) applyStimulus(1);
    endtask

    task automatic waitStrobe(input logic [3:0] idx, input int budget, output logic found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            applyStimulus(1);
            if (reg_rd === 1'b0 && addr_mem_local === idx) found = 1'b1;
        end
    endtask

    initial begin
        int   t0;
        int   hi;
        logic found;

        // Reset values.
        doReset();
        checkOutput("rst_bus_req", bus_req, 1'b0);
        checkOutput("rst_rtc_addr", rtc_addr, 8'h00);
        checkOutput("rst_addr_local", addr_mem_local, 4'hF);
        checkOutput("rst_reg_rd", reg_rd, 1'b1);
        checkOutput("rst_sweep_done", sweep_done, 1'b0);
        checkOutput("rst_timeout_err", timeout_err, 1'b0);

        // Full sweep with immediate acks.
        $display("[TB] full sweep");
        enable = 1'b1;
        t0 = cycle;
        waitRises(1, 40);
        checkOutput("t1_first_tick", rise_cyc[0] - t0, POLL);
        waitDone(100);
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_sweep_len", done_cycle - rise_cyc[0], 40);
        checkOutput("t1_nreads", addr_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t1_addr%0d", i), addr_log[i], exp_addr[i]);
            checkOutput($sformatf("t1_strobe%0d", i), strobe_cnt[i], HOLD);
        end
        waitRises(11, 100);
        checkOutput("t1_next_sweep", rise_cyc[10] - rise_cyc[0], 48);
        checkOutput("t1_done_once", done_cnt, 1);

        // Reset during the strobe of idx 4.
        $display("[TB] reset mid-sweep");
        doReset();
        enable = 1'b1;
        waitStrobe(4'd4, 200, found);
        checkOutput("t2_found_idx4", found, 1'b1);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("t2_reg_rd", reg_rd, 1'b1);
        checkOutput("t2_addr_local", addr_mem_local, 4'hF);
        checkOutput("t2_bus_req", bus_req, 1'b0);
        reset = 1'b0;
        applyStimulus(30);
        checkOutput("t2_no_done", done_cnt, 0);

        // Write path busy at tick, then busy between registers.
        $display("[TB] write path yield");
        doReset();
        enable  = 1'b1;
        wr_busy = 1'b1;
        t0 = cycle;
        applyStimulus(21);
        checkOutput("t3_held_off", addr_log.size(), 0);
        wr_busy = 1'b0;
        t0 = cycle;
        waitRises(1, 20);
        checkOutput("t3_release_lat", rise_cyc[0] - t0, 1);
        waitStrobe(4'd2, 100, found);
        checkOutput("t3_found_idx2", found, 1'b1);
        wr_busy = 1'b1;
        applyStimulus(8);
        checkOutput("t3_gap_reads", addr_log.size(), 3);
        checkOutput("t3_gap_bus_req", bus_req, 1'b0);
        wr_busy = 1'b0;
        t0 = cycle;
        waitRises(4, 20);
        checkOutput("t3_resume_lat", rise_cyc[3] - t0, 1);
        checkOutput("t3_resume_addr", addr_log[3], 8'h24);
        waitDone(100);
        checkOutput("t3_done", done_cnt, 1);

        // Ack withheld for idx 3.
        $display("[TB] ack timeout");
        doReset();
        enable        = 1'b1;
        withhold_en   = 1'b1;
        withhold_addr = 8'h24;
        waitRises(4, 200);
        checkOutput("t4_addr3", addr_log[3], 8'h24);
        hi = 0;
        while (bus_req === 1'b1 && hi < 40) begin
            hi++;
            applyStimulus(1);
        end
        checkOutput("t4_req_len", hi, ATO);
        checkOutput("t4_err_pulse", timeout_err, 1'b1);
        checkOutput("t4_no_strobe3", strobe_cnt[3], 0);
        withhold_en = 1'b0;
        applyStimulus(2);
        checkOutput("t4_err_once", timeout_seen, 1);
        waitRises(5, 100);
        checkOutput("t4_restart_addr", addr_log[4], 8'h21);
        waitDone(100);
        checkOutput("t4_done", done_cnt, 1);

        // Enable dropped during the request of idx 6.
        $display("[TB] enable drop");
        doReset();
        enable = 1'b1;
        waitRises(7, 200);
        checkOutput("t5_addr6", addr_log[6], 8'h27);
        enable = 1'b0;
        applyStimulus(30);
        checkOutput("t5_strobe6", strobe_cnt[6], HOLD);
        checkOutput("t5_no_idx7", addr_log.size(), 7);
        checkOutput("t5_no_done", done_cnt, 0);
        t0 = cycle;
        enable = 1'b1;
        waitRises(8, 40);
        checkOutput("t5_poll_cleared", rise_cyc[7] - t0, POLL);
        checkOutput("t5_restart_addr", addr_log[7], 8'h21);

        // Spurious acks in IDLE and STROBE.
        $display("[TB] spurious acks");
        doReset();
        bus_ack = 1'b1;
        applyStimulus(4);
        checkOutput("t6_idle_bus_req", bus_req, 1'b0);
        checkOutput("t6_idle_reg_rd", reg_rd, 1'b1);
        checkOutput("t6_idle_addr", addr_mem_local, 4'hF);
        checkOutput("t6_idle_reads", addr_log.size(), 0);
        enable = 1'b1;
        waitStrobe(4'd1, 100, found);
        checkOutput("t6_found_idx1", found, 1'b1);
        bus_ack = 1'b1;
        waitDone(100);
        checkOutput("t6_strobe1", strobe_cnt[1], HOLD);
        checkOutput("t6_done", done_cnt, 1);
        checkOutput("t6_sweep_len", done_cycle - rise_cyc[0], 40);
        checkOutput("t6_nreads", addr_log.size(), 10);

        checkOutput("strobe_addr_pairing", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
